// File: rtl/i2c_slave_regctl.sv
// Register-map controller above a byte-level I2C slave: pointer byte then data bytes on write, register stream on read.
// Optional macro I2C_REGCTL_AUTOINC_EN enables pointer auto-increment after each data byte.
module i2c_slave_regctl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slv_start,
    input  logic              slv_rw,
    input  logic              slv_stop,
    input  logic              slv_received,
    input  logic [7:0]        slv_datareceive,
    input  logic              slv_sended,
    output logic              slv_receive,
    output logic              slv_send,
    output logic [7:0]        slv_datasend,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    input  logic              host_we,
    output logic [7:0]        host_rdata,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, PTR, WDATA, READ} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next, ptr_adv;
    logic [7:0]        bank_reg [DEPTH];
    logic              i2c_we;
    logic [7:0]        datasend_reg;
    logic [7:0]        host_rdata_reg;
    logic              wr_stb_reg;
    logic [ADDR_W-1:0] wr_addr_reg;

`ifdef I2C_REGCTL_AUTOINC_EN
    assign ptr_adv = ptr_reg + 1'b1;
`else
    assign ptr_adv = ptr_reg;
`endif

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        i2c_we      = 1'b0;
        slv_receive = 1'b0;
        slv_send    = 1'b0;
        // Byte events are handled in the current state before any start/stop transition.
        case (state_reg)
            PTR: begin
                slv_receive = 1'b1;
                if (slv_received) begin
                    ptr_next   = slv_datareceive[ADDR_W-1:0];
                    state_next = WDATA;
                end
            end
            WDATA: begin
                slv_receive = 1'b1;
                if (slv_received) begin
                    i2c_we   = 1'b1;
                    ptr_next = ptr_adv;
                end
            end
            READ: begin
                slv_send = 1'b1;
                if (slv_sended) begin
                    ptr_next = ptr_adv;
                end
            end
            default: ;
        endcase
        if (slv_stop) begin
            state_next = IDLE;
        end
        if (slv_start) begin
            state_next = slv_rw ? READ : PTR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            datasend_reg   <= 8'h00;
            host_rdata_reg <= 8'h00;
            wr_stb_reg     <= 1'b0;
            wr_addr_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            datasend_reg   <= bank_reg[ptr_next];
            host_rdata_reg <= bank_reg[host_addr];
            wr_stb_reg     <= i2c_we;
            if (i2c_we) begin
                wr_addr_reg <= ptr_reg;
            end
        end
    end

    // I2C write takes priority over a host write to the same byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset) begin
                bank_reg[i] <= 8'h00;
            end else if (i2c_we && ptr_reg == ADDR_W'(i)) begin
                bank_reg[i] <= slv_datareceive;
            end else if (host_we && host_addr == ADDR_W'(i)) begin
                bank_reg[i] <= host_wdata;
            end
        end
    end

    assign slv_datasend = datasend_reg;
    assign host_rdata   = host_rdata_reg;
    assign wr_stb       = wr_stb_reg;
    assign wr_addr      = wr_addr_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_i2c_slave_regctl.sv
// Directed self-checking bench for i2c_slave_regctl; expectations follow I2C_REGCTL_AUTOINC_EN when defined.
module tb_i2c_slave_regctl;

`ifdef I2C_REGCTL_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       slv_start = 1'b0, slv_rw = 1'b0, slv_stop = 1'b0;
    logic       slv_received = 1'b0, slv_sended = 1'b0;
    logic [7:0] slv_datareceive = 8'h00;
    logic       slv_receive, slv_send;
    logic [7:0] slv_datasend;
    logic [3:0] host_addr = 4'h0;
    logic [7:0] host_wdata = 8'h00;
    logic       host_we = 1'b0;
    logic [7:0] host_rdata;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] rd;

    i2c_slave_regctl #(.ADDR_W(4)) dut (
        .clk(clk), .reset(reset),
        .slv_start(slv_start), .slv_rw(slv_rw), .slv_stop(slv_stop),
        .slv_received(slv_received), .slv_datareceive(slv_datareceive),
        .slv_sended(slv_sended), .slv_receive(slv_receive), .slv_send(slv_send),
        .slv_datasend(slv_datasend), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_we(host_we), .host_rdata(host_rdata), .wr_stb(wr_stb),
        .wr_addr(wr_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic i2c_start(input logic rw);
        slv_start = 1'b1; slv_rw = rw;
        tick();
        slv_start = 1'b0;
        $display("start rw=%0d", rw);
    endtask

    task automatic i2c_byte(input logic [7:0] b);
        slv_received = 1'b1; slv_datareceive = b;
        tick();
        slv_received = 1'b0;
        $display("rx byte %02h", b);
    endtask

    task automatic i2c_stop();
        slv_stop = 1'b1;
        tick();
        slv_stop = 1'b0;
        $display("stop");
    endtask

    task automatic i2c_sended();
        slv_sended = 1'b1;
        tick();
        slv_sended = 1'b0;
        $display("sended, datasend=%02h", slv_datasend);
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_we = 1'b0;
        $display("host write [%0d]=%02h", a, d);
    endtask

    task automatic host_rd(input logic [3:0] a, output logic [7:0] d);
        host_addr = a;
        tick();
        d = host_rdata;
        $display("host read [%0d]=%02h", a, d);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++; if (slv_receive !== 1'b0) begin errors++; $display("FAIL rst_receive: got %b expected 0", slv_receive); end
        checks++; if (slv_send !== 1'b0) begin errors++; $display("FAIL rst_send: got %b expected 0", slv_send); end
        checks++; if (slv_datasend !== 8'h00) begin errors++; $display("FAIL rst_datasend: got %h expected 00", slv_datasend); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (wr_stb !== 1'b0 || wr_addr !== 4'h0) begin errors++; $display("FAIL rst_wr: got stb=%b addr=%h expected 0/0", wr_stb, wr_addr); end
        checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h expected 00", host_rdata); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write();
        host_wr(4'd5, 8'h5A);
        i2c_start(1'b0);
        checks++; if (busy !== 1'b1 || slv_receive !== 1'b1 || slv_send !== 1'b0) begin errors++; $display("FAIL wr_enter: got busy=%b rcv=%b snd=%b expected 1/1/0", busy, slv_receive, slv_send); end
        i2c_byte(8'h03);
        i2c_byte(8'hAA);
        checks++; if (wr_stb !== 1'b1 || wr_addr !== 4'd3) begin errors++; $display("FAIL wr_stb1: got stb=%b addr=%h expected 1/3", wr_stb, wr_addr); end
        i2c_byte(8'hBB);
        checks++; if (wr_stb !== 1'b1 || wr_addr !== (AI ? 4'd4 : 4'd3)) begin errors++; $display("FAIL wr_stb2: got stb=%b addr=%h expected 1/%h", wr_stb, wr_addr, AI ? 4'd4 : 4'd3); end
        i2c_stop();
        checks++; if (busy !== 1'b0 || wr_stb !== 1'b0 || slv_receive !== 1'b0) begin errors++; $display("FAIL wr_stop: got busy=%b stb=%b rcv=%b expected 0/0/0", busy, wr_stb, slv_receive); end
        host_rd(4'd3, rd);
        checks++; if (rd !== (AI ? 8'hAA : 8'hBB)) begin errors++; $display("FAIL wr_bank3: got %h expected %h", rd, AI ? 8'hAA : 8'hBB); end
        host_rd(4'd4, rd);
        checks++; if (rd !== (AI ? 8'hBB : 8'h00)) begin errors++; $display("FAIL wr_bank4: got %h expected %h", rd, AI ? 8'hBB : 8'h00); end
        i2c_start(1'b1);
        checks++; if (slv_datasend !== (AI ? 8'h5A : 8'hBB)) begin errors++; $display("FAIL wr_ptr_after: got %h expected %h", slv_datasend, AI ? 8'h5A : 8'hBB); end
        i2c_stop();
    endtask

    task automatic test_read();
        host_wr(4'd2, 8'h12);
        host_wr(4'd3, 8'h13);
        host_wr(4'd4, 8'h14);
        i2c_start(1'b0);
        i2c_byte(8'h02);
        i2c_start(1'b1);
        checks++; if (slv_datasend !== 8'h12 || slv_send !== 1'b1 || slv_receive !== 1'b0) begin errors++; $display("FAIL rd_first: got data=%h snd=%b rcv=%b expected 12/1/0", slv_datasend, slv_send, slv_receive); end
        i2c_sended();
        checks++; if (slv_datasend !== (AI ? 8'h13 : 8'h12)) begin errors++; $display("FAIL rd_second: got %h expected %h", slv_datasend, AI ? 8'h13 : 8'h12); end
        i2c_sended();
        checks++; if (slv_datasend !== (AI ? 8'h14 : 8'h12)) begin errors++; $display("FAIL rd_third: got %h expected %h", slv_datasend, AI ? 8'h14 : 8'h12); end
        i2c_stop();
    endtask

    task automatic test_wrap();
        i2c_start(1'b0);
        i2c_byte(8'h0F);
        i2c_byte(8'h11);
        i2c_byte(8'h22);
        i2c_stop();
        host_rd(4'd15, rd);
        checks++; if (rd !== (AI ? 8'h11 : 8'h22)) begin errors++; $display("FAIL wrap_b15: got %h expected %h", rd, AI ? 8'h11 : 8'h22); end
        host_rd(4'd0, rd);
        checks++; if (rd !== (AI ? 8'h22 : 8'h00)) begin errors++; $display("FAIL wrap_b0: got %h expected %h", rd, AI ? 8'h22 : 8'h00); end
    endtask

    task automatic test_collision();
        i2c_start(1'b0);
        i2c_byte(8'h07);
        host_we = 1'b1; host_addr = 4'd7; host_wdata = 8'h55;
        slv_received = 1'b1; slv_datareceive = 8'h66;
        tick();
        host_we = 1'b0; slv_received = 1'b0;
        $display("collide host [7]=55 i2c [7]=66");
        i2c_stop();
        host_rd(4'd7, rd);
        checks++; if (rd !== 8'h66) begin errors++; $display("FAIL coll_same: got %h expected 66", rd); end
        i2c_start(1'b0);
        i2c_byte(8'h07);
        host_we = 1'b1; host_addr = 4'd8; host_wdata = 8'h77;
        slv_received = 1'b1; slv_datareceive = 8'h99;
        tick();
        host_we = 1'b0; slv_received = 1'b0;
        $display("concurrent host [8]=77 i2c [7]=99");
        i2c_stop();
        host_rd(4'd7, rd);
        checks++; if (rd !== 8'h99) begin errors++; $display("FAIL coll_i2c7: got %h expected 99", rd); end
        host_rd(4'd8, rd);
        checks++; if (rd !== 8'h77) begin errors++; $display("FAIL coll_host8: got %h expected 77", rd); end
    endtask

    task automatic test_same_cycle();
        slv_start = 1'b1; slv_rw = 1'b0; slv_stop = 1'b1;
        tick();
        slv_start = 1'b0; slv_stop = 1'b0;
        $display("start+stop same cycle");
        checks++; if (busy !== 1'b1 || slv_receive !== 1'b1) begin errors++; $display("FAIL start_wins: got busy=%b rcv=%b expected 1/1", busy, slv_receive); end
        i2c_byte(8'h09);
        slv_received = 1'b1; slv_datareceive = 8'h5E; slv_stop = 1'b1;
        tick();
        slv_received = 1'b0; slv_stop = 1'b0;
        $display("byte 5E with stop");
        checks++; if (wr_stb !== 1'b1 || wr_addr !== 4'd9 || busy !== 1'b0) begin errors++; $display("FAIL byte_stop: got stb=%b addr=%h busy=%b expected 1/9/0", wr_stb, wr_addr, busy); end
        host_rd(4'd9, rd);
        checks++; if (rd !== 8'h5E) begin errors++; $display("FAIL byte_stop_bank: got %h expected 5E", rd); end
    endtask

    task automatic test_reset_mid();
        i2c_start(1'b0);
        i2c_byte(8'h01);
        i2c_byte(8'h44);
        checks++; if (wr_stb !== 1'b1) begin errors++; $display("FAIL mid_pre: got stb=%b expected 1", wr_stb); end
        reset = 1'b0;
        tick();
        checks++; if (slv_receive !== 1'b0 || busy !== 1'b0 || wr_stb !== 1'b0 || wr_addr !== 4'd0) begin errors++; $display("FAIL mid_ctrl: got rcv=%b busy=%b stb=%b addr=%h expected 0/0/0/0", slv_receive, busy, wr_stb, wr_addr); end
        checks++; if (slv_datasend !== 8'h00 || host_rdata !== 8'h00) begin errors++; $display("FAIL mid_data: got ds=%h hr=%h expected 00/00", slv_datasend, host_rdata); end
        reset = 1'b1;
        host_rd(4'd1, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mid_bank1: got %h expected 00", rd); end
        host_rd(4'd7, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mid_bank7: got %h expected 00", rd); end
        host_rd(4'd9, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mid_bank9: got %h expected 00", rd); end
    endtask

    task automatic test_ptr_mask();
        host_wr(4'd5, 8'h3C);
        i2c_start(1'b0);
        i2c_byte(8'hF5);
        i2c_start(1'b1);
        checks++; if (slv_datasend !== 8'h3C) begin errors++; $display("FAIL mask_ptr: got %h expected 3C", slv_datasend); end
        host_we = 1'b1; host_addr = 4'd5; host_wdata = 8'h4D;
        tick();
        host_we = 1'b0;
        $display("host write [5]=4D during read");
        checks++; if (slv_datasend !== 8'h3C) begin errors++; $display("FAIL host_ds_early: got %h expected 3C", slv_datasend); end
        tick();
        checks++; if (slv_datasend !== 8'h4D) begin errors++; $display("FAIL host_ds_late: got %h expected 4D", slv_datasend); end
        i2c_stop();
        slv_received = 1'b1; slv_datareceive = 8'hEE;
        tick();
        slv_received = 1'b0;
        $display("rx byte EE in idle");
        tick();
        checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL idle_rx_stb: got %b expected 0", wr_stb); end
        i2c_sended();
        host_rd(4'd5, rd);
        checks++; if (rd !== 8'h4D) begin errors++; $display("FAIL idle_rx_bank: got %h expected 4D", rd); end
        i2c_start(1'b1);
        checks++; if (slv_datasend !== 8'h4D) begin errors++; $display("FAIL idle_sended: got %h expected 4D", slv_datasend); end
        i2c_stop();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_collision();
        test_same_cycle();
        test_reset_mid();
        test_ptr_mask();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
